// File: rtl/pll_reset_sequencer.sv
// Qualifies the PLL lock flag, sequences the NES core reset and generates PPU/CPU clock enables.
// Optional LOCK_LOST_COUNTER_EN macro enables the saturating lock-loss counter.
module pll_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned PPU_DIV            = 4,
    parameter int unsigned CPU_DIV            = 12
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       sys_rst,
    output logic       ready,
    output logic       ppu_ce,
    output logic       cpu_ce,
    output logic [7:0] lock_lost_cnt
);

    localparam int unsigned StabW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int unsigned HoldW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int unsigned DivW  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int unsigned PpuW  = (PPU_DIV > 1) ? $clog2(PPU_DIV) : 1;

    localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD_CYCLES - 1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(CPU_DIV - 1);
    localparam logic [PpuW-1:0]  PpuLast  = PpuW'(PPU_DIV - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StStable,
        StHold,
        StRun
    } state_e;

    state_e state_q, state_d;

    logic lock_meta_q, lock_meta_d;
    logic lock_s_q, lock_s_d;

    logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    // Phase within the current PPU period; stays aligned with div_cnt because
    // CPU_DIV is a multiple of PPU_DIV and both restart at 0 on entry to RUN.
    logic [PpuW-1:0]  ppu_cnt_q, ppu_cnt_d;

    logic sys_rst_q, sys_rst_d;
    logic ready_q, ready_d;
    logic ppu_ce_q, ppu_ce_d;
    logic cpu_ce_q, cpu_ce_d;

    always_comb begin
        lock_meta_d = pll_locked;
        lock_s_d    = lock_meta_q;

        state_d    = state_q;
        stab_cnt_d = '0;
        hold_cnt_d = '0;
        div_cnt_d  = '0;
        ppu_cnt_d  = '0;

        unique case (state_q)
            StWaitLock: begin
                if (lock_s_q) begin
                    state_d = StStable;
                end
            end
            StStable: begin
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                end else if (stab_cnt_q == StabLast) begin
                    state_d = StHold;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                end else begin
                    div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
                    ppu_cnt_d = (ppu_cnt_q == PpuLast) ? '0 : ppu_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase

        // Outputs are registered from the next state so they move on the state-change edge.
        sys_rst_d = (state_d != StRun);
        ready_d   = (state_d == StRun);
        ppu_ce_d  = (state_q == StRun) && (state_d == StRun) && (ppu_cnt_q == PpuLast);
        cpu_ce_d  = (state_q == StRun) && (state_d == StRun) && (div_cnt_q == DivLast);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= StWaitLock;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            stab_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            div_cnt_q   <= '0;
            ppu_cnt_q   <= '0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            ppu_ce_q    <= 1'b0;
            cpu_ce_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            stab_cnt_q  <= stab_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            div_cnt_q   <= div_cnt_d;
            ppu_cnt_q   <= ppu_cnt_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            ppu_ce_q    <= ppu_ce_d;
            cpu_ce_q    <= cpu_ce_d;
        end
    end

    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;
    assign ppu_ce  = ppu_ce_q;
    assign cpu_ce  = cpu_ce_q;

`ifdef LOCK_LOST_COUNTER_EN
    logic       lock_lost_event;
    logic [7:0] lost_cnt_q, lost_cnt_d;

    always_comb begin
        lock_lost_event = (state_q == StRun) && !lock_s_q;
        lost_cnt_d      = lost_cnt_q;
        if (lock_lost_event && (lost_cnt_q != 8'hFF)) begin
            lost_cnt_d = lost_cnt_q + 8'd1;
        end
    end

    // rst has priority, so a loss coinciding with reset is never counted.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lost_cnt_q <= 8'd0;
        end else begin
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign lock_lost_cnt = lost_cnt_q;
`else
    assign lock_lost_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized scoreboard bench for pll_reset_sequencer; the reference model tracks the length of
// the current qualified-lock run and derives every output from it arithmetically.
module tb_pll_reset_sequencer;

    localparam int L      = 8;
    localparam int H      = 4;
    localparam int P      = 4;
    localparam int C      = 12;
    localparam int RUN_AT = L + H + 1;
    localparam int REL    = 3 + L + H;

    typedef struct packed {
        logic       sys_rst;
        logic       ready;
        logic       ppu;
        logic       cpu;
        logic [7:0] lost;
    } exp_t;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       sys_rst;
    logic       ready;
    logic       ppu_ce;
    logic       cpu_ce;
    logic [7:0] lock_lost_cnt;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Model state: run = consecutive edges the FSM has seen a qualified lock.
    int run  = 0;
    int lost = 0;
    bit d1   = 0;
    bit d2   = 0;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .RST_HOLD_CYCLES   (H),
        .PPU_DIV           (P),
        .CPU_DIV           (C)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .ppu_ce       (ppu_ce),
        .cpu_ce       (cpu_ce),
        .lock_lost_cnt(lock_lost_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void model_edge(input bit r, input bit pl);
        exp_t e;
        int   m;
        if (r) begin
            run  = 0;
            lost = 0;
            d1   = 0;
            d2   = 0;
        end else begin
            if (d2) begin
                run++;
            end else begin
                if (run >= RUN_AT) lost = (lost < 255) ? lost + 1 : 255;
                run = 0;
            end
            d2 = d1;
            d1 = pl;
        end
        m         = run - RUN_AT;
        e.sys_rst = (run < RUN_AT);
        e.ready   = (run >= RUN_AT);
        e.ppu     = (run >= RUN_AT) && (m > 0) && (m % P == 0);
        e.cpu     = (run >= RUN_AT) && (m > 0) && (m % C == 0);
`ifdef LOCK_LOST_COUNTER_EN
        e.lost = 8'(lost);
`else
        e.lost = 8'd0;
`endif
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit r, input bit pl);
        @(negedge refclk);
        rst        = r;
        pll_locked = pl;
        @(posedge refclk);
        model_edge(r, pl);
    endtask

    // Holds pll_locked high and counts edges until sys_rst releases.
    task automatic release_latency(input string name);
        int n = -1;
        for (int i = 1; i <= 60; i++) begin
            step(0, 1);
            #1;
            if (sys_rst === 1'b0) begin
                n = i;
                break;
            end
        end
        check(name, n, REL);
    endtask

    task automatic loss_latency(input string name);
        int n = -1;
        for (int i = 1; i <= 10; i++) begin
            step(0, 0);
            #1;
            if (sys_rst === 1'b1) begin
                n = i;
                break;
            end
        end
        check(name, n, 3);
    endtask

    // Monitor: every edge presents a registered output set; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sys_rst", sys_rst, e.sys_rst);
                check("ready", ready, e.ready);
                check("ppu_ce", ppu_ce, e.ppu);
                check("cpu_ce", cpu_ce, e.cpu);
                check("lock_lost_cnt", lock_lost_cnt, e.lost);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ppu_n;
        int cpu_n;
        int exp_lost;
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Reset with lock low.
        repeat (3) step(1, 0);
        step(0, 0);

        // Clean lock, then count enables over two CPU periods.
        release_latency("clean_lock_latency");
        ppu_n = 0;
        cpu_n = 0;
        for (int i = 0; i < 2 * C; i++) begin
            step(0, 1);
            #1;
            if (ppu_ce === 1'b1) ppu_n++;
            if (cpu_ce === 1'b1) begin
                cpu_n++;
                check("cpu_with_ppu", ppu_ce, 1);
            end
        end
        check("ppu_count", ppu_n, 2 * C / P);
        check("cpu_count", cpu_n, 2);

        // Glitchy lock aborts STABLE.
        step(1, 0);
        repeat (5) step(0, 1);
        step(0, 0);
        release_latency("glitch_lock_latency");

        // Lock loss in RUN, then drive the counter into saturation.
`ifdef LOCK_LOST_COUNTER_EN
        exp_lost = 1;
`else
        exp_lost = 0;
`endif
        loss_latency("lock_loss_latency");
        check("first_loss_cnt", lock_lost_cnt, exp_lost);
        for (int i = 1; i < 300; i++) begin
            repeat (REL + $urandom_range(0, 6)) step(0, 1);
            repeat ($urandom_range(1, 3)) step(0, 0);
        end
        repeat (3) step(0, 0);
        #1;
`ifdef LOCK_LOST_COUNTER_EN
        exp_lost = 255;
`else
        exp_lost = 0;
`endif
        check("saturated_cnt", lock_lost_cnt, exp_lost);

        // rst during HOLD restarts the whole sequence.
        step(1, 1);
        repeat (12) step(0, 1);
        step(1, 1);
        #1;
        check("rst_mid_hold_sys_rst", sys_rst, 1);
        release_latency("post_rst_latency");

        // rst and lock loss on the same edge in RUN.
        repeat (5) step(0, 1);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        #1;
        check("rst_loss_cnt", lock_lost_cnt, 0);
        check("rst_loss_sys_rst", sys_rst, 1);
        step(0, 0);

        // Random segments with occasional resets.
        for (int s = 0; s < 60; s++) begin
            bit r0;
            bit pl;
            int len;
            r0  = ($urandom_range(0, 9) == 0);
            pl  = ($urandom_range(0, 3) != 0);
            len = pl ? $urandom_range(1, 40) : $urandom_range(1, 4);
            for (int k = 0; k < len; k++) step((k == 0) ? r0 : 1'b0, pl);
        end

        repeat (2) step(0, 1);
        @(posedge refclk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
